// File: rtl/gf2_mult233_serial_pkg.sv
// Shared constants and types for the GF(2^233) multiplier/reducer slice.
//   M        : field degree (operand width)
//   PROD_W   : width of the unreduced carry-less product (2*M-1)
//   TAP_*    : exponents of the field polynomial x^233 + x^74 + 1, shared
//              with the downstream reducer
//   state_t  : control states of the serial multiplier
//   ndig_of  : number of digit cycles needed for a given digit width
package gf233_pkg;

    localparam int M      = 233;
    localparam int PROD_W = 2 * M - 1;

    localparam int TAP_HI  = 233;
    localparam int TAP_MID = 74;
    localparam int TAP_LO  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(M / digit): how many digit slices cover a full operand
    function automatic int ndig_of(input int digit);
        return (M + digit - 1) / digit;
    endfunction

endpackage

// File: rtl/gf2_mult233_serial_if.sv
// Handshake bundle of the serial GF(2) multiplier.
//   in_valid/in_ready   : operand transfer (a, b)
//   out_valid/out_ready : product transfer
//   product             : raw 465-bit carry-less product
//   busy                : multiplier occupied (computing or holding a result)
// master = producer/consumer side, slave = multiplier side.
interface gf2_mult233_serial_if;
    import gf233_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [M-1:0]      a;
    logic [M-1:0]      b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] product;
    logic              busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/gf2_mult233_serial_digit.sv
// Combinational carry-less multiply of a 233-bit operand by one DIGIT-bit
// slice of the multiplier.
//   a     : 233-bit multiplicand, bit i = x^i
//   d     : DIGIT-bit digit, bit j = x^j
//   clmul : a * d over GF(2), M+DIGIT-1 bits
module gf2_digit_mul233
    import gf233_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [M-1:0]       a,
    input  logic [DIGIT-1:0]   d,
    output logic [M+DIGIT-2:0] clmul
);

    localparam int W = M + DIGIT - 1;

    // one shifted copy of a per set bit of the digit
    logic [DIGIT-1:0][W-1:0] pp;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_pp
        assign pp[gi] = d[gi] ? (W'(a) << gi) : '0;
    end

    always_comb begin
        clmul = '0;
        for (int j = 0; j < DIGIT; j++) begin
            clmul = clmul ^ pp[j];
        end
    end

endmodule

// File: rtl/gf2_mult233_serial.sv
// Digit-serial GF(2) polynomial multiplier, 233 x 233 -> 465 bits unreduced.
// Consumes DIGIT bits of b per cycle, most significant digit first, so the
// product is ready NDIG cycles after the operands are accepted.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset; aborts any operation in flight
//   bus   : slave modport carrying in_valid/in_ready/a/b,
//           out_valid/out_ready/product and busy
module gf2_mult233_serial
    import gf233_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gf2_mult233_serial_if.slave  bus
);

    localparam int NDIG = ndig_of(DIGIT);
    localparam int BW   = NDIG * DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CM_W = M + DIGIT - 1;

    state_t            state_reg;
    state_t            state_next;
    logic [CW-1:0]     cnt_reg;
    logic [M-1:0]      a_reg;
    logic [BW-1:0]     b_reg;
    logic [PROD_W-1:0] acc_reg;
    logic [PROD_W-1:0] acc_next;
    logic [PROD_W-1:0] product_reg;
    logic [CM_W-1:0]   clmul;

    logic in_ready;
    logic out_valid;
    logic busy;
    logic accept;
    logic last;

    assign accept = bus.in_valid && in_ready;
    assign last   = (cnt_reg == CW'(NDIG - 1));

    gf2_digit_mul233 #(.DIGIT(DIGIT)) u_digit (
        .a     (a_reg),
        .d     (b_reg[BW-1 -: DIGIT]),
        .clmul (clmul)
    );

    // Horner step: the top digit of the 465-bit window can never overflow,
    // because b is zero-extended in its high digits.
    assign acc_next = (acc_reg << DIGIT) ^ PROD_W'(clmul);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)        state_next = BUSY;
            BUSY:    if (last)          state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // outputs; in_ready also drops while reset is asserted
    always_comb begin
        in_ready  = (state_reg == IDLE) && rst_n;
        out_valid = (state_reg == DONE);
        busy      = (state_reg != IDLE);
    end

    // datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            product_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (accept) begin
                a_reg   <= bus.a;
                b_reg   <= BW'(bus.b);
                acc_reg <= '0;
                cnt_reg <= '0;
            end
        end else if (state_reg == BUSY) begin
            acc_reg <= acc_next;
            b_reg   <= b_reg << DIGIT;
            cnt_reg <= cnt_reg + 1'b1;
            if (last) begin
                product_reg <= acc_next;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.product   = product_reg;

endmodule

// File: tb/tb_gf2_mult233_serial.sv
// Bench for gf2_mult233_serial: three instances (DIGIT = 1, 8, 233) run in
// parallel. Each has a cycle-level expectation of the handshake outputs and
// the product register, plus a transaction driver with random stalls.
module tb_gf2_mult233_serial;
    import gf233_pkg::*;

    logic clk;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic              rst_v       [3];
    logic              in_valid_v  [3];
    logic [M-1:0]      a_v         [3];
    logic [M-1:0]      b_v         [3];
    logic              out_ready_v [3];
    logic              in_ready_v  [3];
    logic              out_valid_v [3];
    logic              busy_v      [3];
    logic [PROD_W-1:0] product_v   [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference arithmetic ----------------
    function automatic logic [464:0] clmul(input logic [232:0] x, input logic [232:0] y);
        logic [464:0] r;
        r = '0;
        for (int i = 0; i < 233; i++)
            if (y[i]) r = r ^ ({232'b0, x} << i);
        return r;
    endfunction

    // x^i for i >= 233 folds to x^(i-159) + x^(i-233)
    function automatic logic [232:0] reduce(input logic [464:0] p);
        logic [464:0] q;
        q = p;
        for (int i = 464; i >= 233; i--)
            if (q[i]) begin
                q[i]       = 1'b0;
                q[i - 159] = ~q[i - 159];
                q[i - 233] = ~q[i - 233];
            end
        return q[232:0];
    endfunction

    // interleaved shift-and-add multiply modulo x^233 + x^74 + 1
    function automatic logic [232:0] gf_mul(input logic [232:0] x, input logic [232:0] y);
        logic [232:0] r;
        logic         c;
        r = '0;
        for (int i = 232; i >= 0; i--) begin
            c = r[232];
            r = {r[231:0], 1'b0};
            if (c) begin
                r[0]  = ~r[0];
                r[74] = ~r[74];
            end
            if (y[i]) r = r ^ x;
        end
        return r;
    endfunction

    function automatic logic [232:0] rand233();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r[232:0];
    endfunction

    function automatic int dig_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 8 : 233;
    endfunction

    task automatic check(input int dig, input string name,
                         input logic [464:0] act, input logic [464:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL d%0d %s: got %0h expected %0h", dig, name, act, exp);
        end
    endtask

    // ---------------- instances and per-cycle comparison ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int D  = (gi == 0) ? 1 : (gi == 1) ? 8 : 233;
        localparam int ND = (233 + D - 1) / D;

        gf2_mult233_serial_if ifc ();

        gf2_mult233_serial #(.DIGIT(D)) dut (
            .clk   (clk),
            .rst_n (rst_v[gi]),
            .bus   (ifc.slave)
        );

        assign ifc.in_valid    = in_valid_v[gi];
        assign ifc.a           = a_v[gi];
        assign ifc.b           = b_v[gi];
        assign ifc.out_ready   = out_ready_v[gi];
        assign in_ready_v[gi]  = ifc.in_ready;
        assign out_valid_v[gi] = ifc.out_valid;
        assign busy_v[gi]      = ifc.busy;
        assign product_v[gi]   = ifc.product;

        bit           armed = 1'b0;
        bit           pend  = 1'b0;
        int           due   = 0;
        logic [464:0] exp_prod;
        logic [464:0] prod_hold;

        // expected state advances on each edge from the inputs the DUT sees
        initial forever begin
            bit ev;
            @(posedge clk);
            ev = pend && (cyc >= due);
            if (!rst_v[gi]) begin
                armed     = 1'b1;
                pend      = 1'b0;
                prod_hold = '0;
            end else if (!pend && in_valid_v[gi]) begin
                pend     = 1'b1;
                due      = cyc + 1 + ND;
                exp_prod = clmul(a_v[gi], b_v[gi]);
            end else if (ev && out_ready_v[gi]) begin
                pend      = 1'b0;
                prod_hold = exp_prod;
            end
        end

        initial forever begin
            bit ev;
            @(negedge clk);
            if (armed) begin
                ev = pend && (cyc >= due);
                check(D, "out_valid", ifc.out_valid, ev);
                check(D, "in_ready", ifc.in_ready, !pend && rst_v[gi]);
                check(D, "busy", ifc.busy, pend);
                check(D, "product", ifc.product, ev ? exp_prod : prod_hold);
            end
        end
    end

    // ---------------- transaction driver ----------------
    // hold: cycles of forced out_ready=0 in DONE while in_valid/a/b toggle
    task automatic do_op(input int k, input logic [232:0] av, input logic [232:0] bv,
                         input int stall_pct, input int hold,
                         output logic [464:0] prod, output int lat);
        int n;
        int nd;
        nd = ndig_of(dig_of(k));
        @(posedge clk); #1;
        a_v[k] = av; b_v[k] = bv; in_valid_v[k] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready_v[k] && n < 50) begin n++; @(negedge clk); end
        if (!in_ready_v[k]) check(dig_of(k), "accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid_v[k] = 1'b0; a_v[k] = rand233(); b_v[k] = rand233();
        lat = 0;
        @(negedge clk);
        while (!out_valid_v[k] && lat < nd + 20) begin
            out_ready_v[k] = 1'($urandom_range(0, 1));
            @(posedge clk); lat++;
            @(negedge clk);
        end
        if (!out_valid_v[k]) check(dig_of(k), "result_timeout", 0, 1);
        n = 0;
        do begin
            prod = product_v[k];
            if (n < hold) begin
                out_ready_v[k] = 1'b0;
                in_valid_v[k]  = 1'($urandom_range(0, 1));
                a_v[k] = rand233(); b_v[k] = rand233();
            end else begin
                in_valid_v[k]  = 1'b0;
                out_ready_v[k] = ($urandom_range(0, 99) >= stall_pct);
            end
            n++;
            if (!out_ready_v[k]) @(negedge clk);
        end while (!out_ready_v[k] && n < hold + 200);
        @(posedge clk); #1;
        out_ready_v[k] = 1'b0;
    endtask

    task automatic directed(input int k);
        logic [464:0] p;
        logic [464:0] e;
        logic [232:0] x;
        logic [232:0] y;
        int           lat;

        do_op(k, 233'd1, 233'd1, 0, 0, p, lat);
        check(8, "lat_1x1", lat, 30);
        check(8, "prod_1x1", p, 1);
        $display("d8 directed 1*1: lat %0d prod %0h", lat, p);

        do_op(k, 233'd3, 233'd3, 0, 0, p, lat);
        check(8, "prod_3x3", p, 5);
        $display("d8 directed 3*3: prod %0h", p);

        do_op(k, 233'd7, 233'd3, 0, 0, p, lat);
        check(8, "prod_7x3", p, 9);
        $display("d8 directed 7*3: prod %0h", p);

        x = '0; x[232] = 1'b1;
        e = '0; e[464] = 1'b1;
        do_op(k, x, x, 0, 0, p, lat);
        check(8, "prod_top", p, e);
        $display("d8 directed x^232*x^232: prod %0h", p);

        x = '1;
        e = '0; e[232:0] = '1;
        do_op(k, x, 233'd1, 0, 0, p, lat);
        check(8, "prod_ones", p, e);
        $display("d8 directed ones*1: prod %0h", p);

        // backpressure: 10 cycles held in DONE with noise on the inputs
        x = rand233(); y = rand233();
        do_op(k, x, y, 0, 10, p, lat);
        check(8, "prod_bp", p, clmul(x, y));
        @(negedge clk);
        check(8, "in_ready_after_bp", in_ready_v[k], 1);
        $display("d8 directed backpressure: lat %0d", lat);

        // reset in the middle of BUSY
        @(posedge clk); #1;
        a_v[k] = rand233(); b_v[k] = rand233(); in_valid_v[k] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[k] = 1'b0;
        @(negedge clk);
        check(8, "busy_before_rst", busy_v[k], 1);
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst_v[k] = 1'b0;
        @(negedge clk);
        check(8, "out_valid_after_rst", out_valid_v[k], 0);
        check(8, "product_after_rst", product_v[k], 0);
        check(8, "busy_after_rst", busy_v[k], 0);
        rst_v[k] = 1'b1;
        do_op(k, 233'd3, 233'd3, 0, 0, p, lat);
        check(8, "lat_after_rst", lat, 30);
        check(8, "prod_after_rst", p, 5);
        $display("d8 directed reset-abort then 3*3: lat %0d prod %0h", lat, p);
    endtask

    task automatic run(input int k);
        int           dig;
        int           nd;
        int           n_ops;
        int           lat;
        logic [232:0] x;
        logic [232:0] y;
        logic [464:0] p;
        dig = dig_of(k);
        nd  = ndig_of(dig);
        repeat (3) @(posedge clk);
        #1 rst_v[k] = 1'b1;
        if (k == 1) directed(k);
        n_ops = (dig == 1) ? 100 : 1000;
        for (int i = 0; i < n_ops; i++) begin
            x = rand233();
            y = rand233();
            if ($urandom_range(0, 7) == 0) y = 233'd1 << $urandom_range(0, 232);
            do_op(k, x, y, 25, 0, p, lat);
            check(dig, "rand_prod", p, clmul(x, y));
            check(dig, "rand_reduced", reduce(p), gf_mul(x, y));
            check(dig, "rand_latency", lat, nd);
            $display("d%0d op %0d: lat %0d prod[63:0] %h", dig, i, lat, p[63:0]);
        end
    endtask

    initial begin
        logic [464:0] e;
        logic [232:0] x;
        for (int k = 0; k < 3; k++) begin
            rst_v[k] = 1'b0; in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
            a_v[k] = '0; b_v[k] = '0;
        end
        // hand-computed values that pin the reference functions
        check(0, "pin_clmul_3x3", clmul(233'd3, 233'd3), 5);
        check(0, "pin_clmul_7x3", clmul(233'd7, 233'd3), 9);
        x = '0; x[232] = 1'b1;
        e = '0; e[464] = 1'b1;
        check(0, "pin_clmul_top", clmul(x, x), e);
        e = '0; e[74] = 1'b1; e[0] = 1'b1;
        check(0, "pin_gf_wrap", gf_mul(x, 233'd2), e);
        e = '0; e[233] = 1'b1;
        check(0, "pin_reduce", reduce(e), gf_mul(x, 233'd2));

        fork
            run(0);
            run(1);
            run(2);
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
